// File: rtl/uart_pkg.sv
// Shared UART types and helpers: parity modes, receiver FSM states and
// the frame-length helper.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BRK_WAIT
  } rx_state_e;

  // Total bits on the wire for one frame, start bit included.
  function automatic int frame_bits(input int data_bits, input int parity_mode,
                                    input int stop_bits);
    return 1 + data_bits + ((parity_mode != 0) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous serial line; both flops reset to
// RST_VAL so a freshly reset channel sees an idle line.
module uart_rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic meta;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      meta <= RST_VAL;
      o_q  <= RST_VAL;
    end else begin
      meta <= i_d;
      o_q  <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: configurable data width, parity and stop bits,
// start-bit glitch rejection and parity/framing/break reporting.
//
// state       | meaning
// ST_IDLE     | line idle, waiting for synchronised rx low
// ST_START    | timing to mid start bit; high there means glitch
// ST_DATA     | sampling data bits, LSB first
// ST_PARITY   | sampling the parity bit
// ST_STOP     | sampling stop bit(s); final sample delivers the word
// ST_BRK_WAIT | break reported, waiting for the line to return high
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BAUD = 868,
  parameter int DATA_BITS     = 8,
  parameter int PARITY_MODE   = 0,
  parameter int STOP_BITS     = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_dvalid,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_break,
  output logic                 o_busy
);

  localparam int CW = $clog2(CLKS_PER_BAUD);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BAUD / 2 - 1);
  localparam logic [CW-1:0] BAUD_LOAD = CW'(CLKS_PER_BAUD - 1);
  localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_BITS - 1);
  localparam logic PAR_EN       = (PARITY_MODE != int'(PAR_NONE));
  localparam logic PAR_ODD_MODE = (PARITY_MODE == int'(PAR_ODD));
  localparam logic STOP_LAST    = (STOP_BITS == 2);

  if (CLKS_PER_BAUD < 8) begin : g_chk_baud
    $error("uart_rx_cfg: CLKS_PER_BAUD must be >= 8");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data
    $error("uart_rx_cfg: DATA_BITS must be 5..9");
  end
  if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_chk_par
    $error("uart_rx_cfg: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
    $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
  end

  logic                 rx_s;
  rx_state_e            state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 frm_acc;
  logic                 stop_hi;
  logic                 tick;
  logic                 par_bad;
  logic                 is_break;

  uart_rx_sync #(.RST_VAL(1'b1)) u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_rx),
    .o_q   (rx_s)
  );

  assign tick    = (cnt == '0);
  assign par_bad = PAR_EN && ((^{shreg, par_bit}) != PAR_ODD_MODE);
  // Break needs every sampled bit low: data, parity (if any), all stop bits.
  assign is_break = (shreg == '0) && !(PAR_EN && par_bit) && !stop_hi && !rx_s;
  assign o_busy   = (state != ST_IDLE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      stop_idx     <= 1'b0;
      shreg        <= '0;
      par_bit      <= 1'b0;
      frm_acc      <= 1'b0;
      stop_hi      <= 1'b0;
      o_rx_data    <= '0;
      o_rx_dvalid  <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_break      <= 1'b0;
    end else begin
      o_rx_dvalid <= 1'b0;

      if (state inside {ST_START, ST_DATA, ST_PARITY, ST_STOP}) begin
        cnt <= tick ? BAUD_LOAD : cnt - 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state <= ST_START;
            cnt   <= HALF_LOAD;
          end
        end
        ST_START: begin
          if (tick) begin
            if (rx_s) begin
              state <= ST_IDLE;
            end else begin
              state   <= ST_DATA;
              bit_idx <= '0;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            if (bit_idx == LAST_BIT) begin
              state    <= PAR_EN ? ST_PARITY : ST_STOP;
              stop_idx <= 1'b0;
              frm_acc  <= 1'b0;
              stop_hi  <= 1'b0;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            par_bit <= rx_s;
            state   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (stop_idx == STOP_LAST) begin
              o_rx_dvalid  <= 1'b1;
              o_rx_data    <= shreg;
              o_parity_err <= par_bad;
              o_frame_err  <= frm_acc | ~rx_s;
              o_break      <= is_break;
              // Leaving at mid stop bit lets a back-to-back start edge be caught.
              state        <= is_break ? ST_BRK_WAIT : ST_IDLE;
            end else begin
              stop_idx <= 1'b1;
              frm_acc  <= frm_acc | ~rx_s;
              stop_hi  <= stop_hi | rx_s;
            end
          end
        end
        ST_BRK_WAIT: begin
          if (rx_s) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: three channels (8N1, 7E2, 9O1) driven with
// directed and random frames, checked against a frame-level reference model.
module tb_uart_rx_cfg;

  typedef struct {
    logic [8:0] data;
    logic       pe;
    logic       fe;
    logic       bk;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] rx;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  exp_t       exp_q[3][$];
  logic       prev_dv[3];

  logic [7:0] d0;
  logic [6:0] d1;
  logic [8:0] d2;
  logic dv0, dv1, dv2, pe0, pe1, pe2, fe0, fe1, fe2, bk0, bk1, bk2, by0, by1, by2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_cfg #(.CLKS_PER_BAUD(16), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_rx(rx[0]), .o_rx_data(d0), .o_rx_dvalid(dv0),
    .o_parity_err(pe0), .o_frame_err(fe0), .o_break(bk0), .o_busy(by0));
  uart_rx_cfg #(.CLKS_PER_BAUD(16), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_rx(rx[1]), .o_rx_data(d1), .o_rx_dvalid(dv1),
    .o_parity_err(pe1), .o_frame_err(fe1), .o_break(bk1), .o_busy(by1));
  uart_rx_cfg #(.CLKS_PER_BAUD(12), .DATA_BITS(9), .PARITY_MODE(1), .STOP_BITS(1)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_rx(rx[2]), .o_rx_data(d2), .o_rx_dvalid(dv2),
    .o_parity_err(pe2), .o_frame_err(fe2), .o_break(bk2), .o_busy(by2));

  function automatic int cfg_c(input int i); return (i == 2) ? 12 : 16; endfunction
  function automatic int cfg_d(input int i); return (i == 0) ? 8 : (i == 1) ? 7 : 9; endfunction
  function automatic int cfg_p(input int i); return (i == 0) ? 0 : (i == 1) ? 2 : 1; endfunction
  function automatic int cfg_s(input int i); return (i == 1) ? 2 : 1; endfunction

  // Expected delivery from the bits actually placed on the wire.
  function automatic exp_t model(input int idx, input logic [8:0] word, input logic pbit,
                                 input logic [1:0] stops, input int fall);
    exp_t e;
    int d = cfg_d(idx), p = cfg_p(idx), s = cfg_s(idx), c = cfg_c(idx);
    int ones = 0;
    bit all_low = 1'b1, any_low = 1'b0;
    for (int i = 0; i < 9; i++) begin
      e.data[i] = (i < d) ? word[i] : 1'b0;
      if (i < d && word[i]) ones++;
    end
    for (int i = 0; i < s; i++) begin
      if (stops[i] == 1'b0) any_low = 1'b1;
      else all_low = 1'b0;
    end
    e.pe  = (p != 0) && (((ones + int'(pbit)) % 2) != ((p == 1) ? 1 : 0));
    e.fe  = any_low;
    e.bk  = (ones == 0) && (p == 0 || pbit == 1'b0) && all_low;
    e.cyc = fall + 2 + c / 2 + (d + ((p != 0) ? 1 : 0) + s) * c + 1;
    return e;
  endfunction

  task automatic send_frame(input int idx, input logic [8:0] word, input logic flip_par,
                            input logic [1:0] stops, input int gap_bits);
    bit   bits[$];
    int   d = cfg_d(idx), p = cfg_p(idx), s = cfg_s(idx), c = cfg_c(idx);
    int   ones = 0;
    logic pbit = 1'b0;
    for (int i = 0; i < d; i++) if (word[i]) ones++;
    if (p == 2) pbit = logic'(ones % 2);
    if (p == 1) pbit = logic'((ones + 1) % 2);
    pbit = pbit ^ flip_par;
    exp_q[idx].push_back(model(idx, word, pbit, stops, cyc));
    bits.push_back(1'b0);
    for (int i = 0; i < d; i++) bits.push_back(word[i]);
    if (p != 0) bits.push_back(pbit);
    for (int i = 0; i < s; i++) bits.push_back(stops[i]);
    foreach (bits[i]) begin
      rx[idx] = bits[i];
      repeat (c) @(negedge clk);
    end
    rx[idx] = 1'b1;
    repeat (gap_bits * c) @(negedge clk);
  endtask

  task automatic send_break(input int idx, input int nbits);
    exp_q[idx].push_back(model(idx, 9'h000, 1'b0, 2'b00, cyc));
    rx[idx] = 1'b0;
    repeat (nbits * cfg_c(idx)) @(negedge clk);
    rx[idx] = 1'b1;
    repeat (2 * cfg_c(idx)) @(negedge clk);
  endtask

  task automatic check_out(input int idx, input logic v, input logic [8:0] data,
                           input logic p, input logic f, input logic b);
    exp_t e;
    if (v) begin
      n_cmp++;
      if (prev_dv[idx]) begin
        n_bad++;
        $display("FAIL strobe_width ch%0d: dvalid high on consecutive cycles at cyc=%0d, required a 1-cycle strobe", idx, cyc);
      end else if (exp_q[idx].size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_strobe ch%0d: strobe at cyc=%0d data=%h, required no strobe", idx, cyc, data);
      end else begin
        e = exp_q[idx].pop_front();
        if (data !== e.data || p !== e.pe || f !== e.fe || b !== e.bk || cyc != e.cyc) begin
          n_bad++;
          $display("FAIL rx_word ch%0d: got data=%h pe=%b fe=%b brk=%b cyc=%0d, required data=%h pe=%b fe=%b brk=%b cyc=%0d",
                   idx, data, p, f, b, cyc, e.data, e.pe, e.fe, e.bk, e.cyc);
        end
      end
    end
    prev_dv[idx] = v;
  endtask

  always @(negedge clk) begin
    check_out(0, dv0, {1'b0, d0}, pe0, fe0, bk0);
    check_out(1, dv1, {2'b00, d1}, pe1, fe1, bk1);
    check_out(2, dv2, d2, pe2, fe2, bk2);
  end

  task automatic check_reset(input int idx, input logic [8:0] data, input logic v,
                             input logic p, input logic f, input logic b, input logic busy);
    n_cmp++;
    if (data !== 9'h000 || v !== 1'b0 || p !== 1'b0 || f !== 1'b0 || b !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_values ch%0d: got data=%h dv=%b pe=%b fe=%b brk=%b busy=%b, required all 0",
               idx, data, v, p, f, b, busy);
    end
  endtask

  task automatic check_all_reset();
    check_reset(0, {1'b0, d0}, dv0, pe0, fe0, bk0, by0);
    check_reset(1, {2'b00, d1}, dv1, pe1, fe1, bk1, by1);
    check_reset(2, d2, dv2, pe2, fe2, bk2, by2);
  endtask

  initial begin
    logic [8:0] word;
    logic [1:0] stops;
    logic       flip;
    bit         saw_hi;
    int         drop;
    int         fall;
    int         gap;
    prev_dv[0] = 1'b0; prev_dv[1] = 1'b0; prev_dv[2] = 1'b0;
    rst = 1'b1;
    rx  = 3'b111;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    check_all_reset();
    repeat (3) @(negedge clk);

    send_frame(0, 9'h0A5, 1'b0, 2'b11, 2);
    send_frame(1, 9'h041, 1'b1, 2'b11, 2);
    send_frame(1, 9'h041, 1'b0, 2'b11, 2);
    send_frame(0, 9'h03C, 1'b0, 2'b10, 3);
    send_frame(2, 9'h1C3, 1'b0, 2'b11, 1);
    send_frame(2, 9'h0F0, 1'b1, 2'b11, 1);

    // Short low pulse: busy must rise and drop back, no strobe.
    fall   = cyc;
    saw_hi = 1'b0;
    drop   = -1;
    rx[0]  = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 5) rx[0] = 1'b1;
      if (by0) saw_hi = 1'b1;
      else if (saw_hi && drop < 0) drop = cyc - fall;
    end
    n_cmp++;
    if (!saw_hi || drop < 0 || drop > 11) begin
      n_bad++;
      $display("FAIL glitch_busy: busy_seen=%b returned_after=%0d cycles, required busy seen and return within 11", saw_hi, drop);
    end
    repeat (16) @(negedge clk);

    send_break(0, 40);
    send_frame(0, 9'h055, 1'b0, 2'b11, 2);
    send_break(1, 40);
    send_frame(1, 9'h02A, 1'b0, 2'b11, 2);
    send_break(2, 40);
    send_frame(2, 9'h155, 1'b0, 2'b11, 2);

    send_frame(0, 9'h000, 1'b0, 2'b11, 0);
    send_frame(0, 9'h0FF, 1'b0, 2'b11, 0);
    rx[0] = 1'b0;
    repeat (3 * 16) @(negedge clk);
    rst   = 1'b1;
    rx[0] = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset(0, {1'b0, d0}, dv0, pe0, fe0, bk0, by0);
    repeat (300) @(negedge clk);
    check_reset(0, {1'b0, d0}, dv0, pe0, fe0, bk0, by0);

    for (int ch = 0; ch < 3; ch++) begin
      for (int n = 0; n < 25; n++) begin
        word  = 9'($urandom);
        if ($urandom_range(0, 7) == 0) word = 9'h000;
        flip  = (cfg_p(ch) != 0) && ($urandom_range(0, 3) == 0);
        stops = 2'b11;
        if ($urandom_range(0, 5) == 0) stops[$urandom_range(0, cfg_s(ch) - 1)] = 1'b0;
        gap   = (stops != 2'b11) ? 2 : $urandom_range(0, 1);
        send_frame(ch, word, flip, stops, gap);
      end
      repeat (2 * cfg_c(ch)) @(negedge clk);
    end

    for (int t = 0; t < 3000; t++) begin
      if (exp_q[0].size() == 0 && exp_q[1].size() == 0 && exp_q[2].size() == 0) break;
      @(negedge clk);
    end
    for (int ch = 0; ch < 3; ch++) begin
      n_cmp++;
      if (exp_q[ch].size() != 0) begin
        n_bad++;
        $display("FAIL missing_strobe ch%0d: %0d words still expected, required 0", ch, exp_q[ch].size());
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
